wt_store_wbuf: RTL

//  In-order store write buffer between the load/store unit's store path and the

---
 rtl/wt_store_wbuf.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/wt_store_wbuf.sv
// In-order store write buffer between the LSU store path and a write-through D$ memory port.
// Same-word stores coalesce into the youngest pending entry; entries issue with a TID and retire on ack.

module wt_wbuf_entry #(
  parameter int XLEN  = 64,
  parameter int WAW   = 61,
  parameter int TID_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_alloc,
  input  logic              i_merge,
  input  logic              i_issue,
  input  logic              i_retire,
  input  logic [WAW-1:0]    i_waddr,
  input  logic [XLEN-1:0]   i_data,
  input  logic [XLEN/8-1:0] i_be,
  input  logic [TID_W-1:0]  i_tid,
  input  logic [WAW-1:0]    i_ld_waddr,
  output logic              o_pend,
  output logic [WAW-1:0]    o_waddr,
  output logic [XLEN-1:0]   o_data,
  output logic [XLEN/8-1:0] o_be,
  output logic [TID_W-1:0]  o_tid,
  output logic              o_ld_hit
);
  typedef enum logic [1:0] {S_FREE = 2'd0, S_PEND = 2'd1, S_ISSUED = 2'd2} state_e;

  state_e              r_state, w_state_nxt;
  logic [WAW-1:0]      r_waddr;
  logic [XLEN-1:0]     r_data;
  logic [XLEN/8-1:0]   r_be;
  logic [TID_W-1:0]    r_tid;
  logic [XLEN-1:0]     w_mask;

  for (genvar b = 0; b < XLEN/8; b++) begin : g_mask
    assign w_mask[8*b +: 8] = {8{i_be[b]}};
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FREE:   if (i_alloc)  w_state_nxt = S_PEND;
      S_PEND:   if (i_issue)  w_state_nxt = S_ISSUED;
      S_ISSUED: if (i_retire) w_state_nxt = S_FREE;
      default:  w_state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_FREE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_waddr <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_tid   <= '0;
    end else begin
      if (i_alloc) begin
        r_waddr <= i_waddr;
        r_data  <= i_data;
        r_be    <= i_be;
      end else if (i_merge) begin
        r_data  <= (r_data & ~w_mask) | (i_data & w_mask);
        r_be    <= r_be | i_be;
      end
      if (i_issue) r_tid <= i_tid;
    end
  end

  assign o_pend   = (r_state == S_PEND);
  assign o_waddr  = r_waddr;
  assign o_data   = r_data;
  assign o_be     = r_be;
  assign o_tid    = r_tid;
  assign o_ld_hit = (r_state != S_FREE) && (r_waddr == i_ld_waddr);
endmodule

module wt_store_wbuf #(
  parameter int XLEN  = 64,
  parameter int AW    = 64,
  parameter int DEPTH = 8,
  parameter int TID_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              st_valid_i,
  output logic              st_ready_o,
  input  logic [AW-1:0]     st_addr_i,
  input  logic [XLEN-1:0]   st_data_i,
  input  logic [XLEN/8-1:0] st_be_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [AW-1:0]     mem_addr_o,
  output logic [XLEN-1:0]   mem_data_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [TID_W-1:0]  mem_tid_o,
  input  logic              mem_ack_i,
  input  logic [TID_W-1:0]  mem_ack_tid_i,
  input  logic [AW-1:0]     ld_addr_i,
  output logic              ld_hit_o,
  output logic              empty_o
);
  localparam int OFF    = $clog2(XLEN/8);
  localparam int WAW    = AW - OFF;
  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int MAXOUT = ((1 << TID_W) < DEPTH) ? (1 << TID_W) : DEPTH;
  localparam int OW     = $clog2(MAXOUT + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAXOUT);

  logic [PW-1:0]    r_wr_ptr, r_iss_ptr, r_ret_ptr;
  logic [CW-1:0]    r_count;
  logic [OW-1:0]    r_outst;
  logic [TID_W-1:0] r_tid_cnt;

  logic [DEPTH-1:0]             w_pend, w_ld_hit;
  logic [DEPTH-1:0]             w_alloc_v, w_merge_v, w_issue_v, w_retire_v;
  logic [DEPTH-1:0][WAW-1:0]    w_waddr;
  logic [DEPTH-1:0][XLEN-1:0]   w_data;
  logic [DEPTH-1:0][XLEN/8-1:0] w_be;
  logic [DEPTH-1:0][TID_W-1:0]  w_tid;

  logic [WAW-1:0] w_st_waddr, w_ld_waddr;
  logic [PW-1:0]  w_young;
  logic           w_full, w_can_merge, w_merge, w_alloc, w_gnt, w_ack;
  logic           w_unused_lo;

  assign w_st_waddr  = st_addr_i[AW-1:OFF];
  assign w_ld_waddr  = ld_addr_i[AW-1:OFF];
  assign w_unused_lo = ^{st_addr_i[OFF-1:0], ld_addr_i[OFF-1:0]};
  assign w_young     = r_wr_ptr - PW'(1);

  assign mem_req_o = w_pend[r_iss_ptr] && (r_outst < OUT_MAX);
  assign w_gnt     = mem_req_o && mem_gnt_i;
  // Acks with nothing outstanding (e.g. stragglers from before a reset) are dropped.
  assign w_ack     = mem_ack_i && (r_outst != '0);

  // Only the youngest entry can absorb a store, and never in the cycle it leaves as a write.
  assign w_full      = (r_count == CNT_FULL);
  assign w_can_merge = w_pend[w_young] && (w_waddr[w_young] == w_st_waddr) &&
                       !(w_gnt && (r_iss_ptr == w_young));
  assign w_merge     = st_valid_i && w_can_merge;
  assign w_alloc     = st_valid_i && !w_can_merge && !w_full;
  assign st_ready_o  = w_can_merge || !w_full;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign w_alloc_v[i]  = w_alloc && (r_wr_ptr  == PW'(i));
    assign w_merge_v[i]  = w_merge && (w_young   == PW'(i));
    assign w_issue_v[i]  = w_gnt   && (r_iss_ptr == PW'(i));
    assign w_retire_v[i] = w_ack   && (r_ret_ptr == PW'(i));

    wt_wbuf_entry #(.XLEN(XLEN), .WAW(WAW), .TID_W(TID_W)) u_ent (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_alloc    (w_alloc_v[i]),
      .i_merge    (w_merge_v[i]),
      .i_issue    (w_issue_v[i]),
      .i_retire   (w_retire_v[i]),
      .i_waddr    (w_st_waddr),
      .i_data     (st_data_i),
      .i_be       (st_be_i),
      .i_tid      (r_tid_cnt),
      .i_ld_waddr (w_ld_waddr),
      .o_pend     (w_pend[i]),
      .o_waddr    (w_waddr[i]),
      .o_data     (w_data[i]),
      .o_be       (w_be[i]),
      .o_tid      (w_tid[i]),
      .o_ld_hit   (w_ld_hit[i])
    );
  end

  assign mem_addr_o = {w_waddr[r_iss_ptr], {OFF{1'b0}}};
  assign mem_data_o = w_data[r_iss_ptr];
  assign mem_be_o   = w_be[r_iss_ptr];
  assign mem_tid_o  = r_tid_cnt;
  assign ld_hit_o   = |w_ld_hit;
  assign empty_o    = (r_count == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_iss_ptr <= '0;
      r_ret_ptr <= '0;
      r_count   <= '0;
      r_outst   <= '0;
      r_tid_cnt <= '0;
    end else begin
      if (w_alloc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_gnt) begin
        r_iss_ptr <= r_iss_ptr + PW'(1);
        r_tid_cnt <= r_tid_cnt + TID_W'(1);
      end
      if (w_ack) r_ret_ptr <= r_ret_ptr + PW'(1);
      r_count <= r_count + CW'(w_alloc) - CW'(w_ack);
      r_outst <= r_outst + OW'(w_gnt) - OW'(w_ack);
    end
  end

  a_ack_outst: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mem_ack_i |-> (r_outst != '0));
  a_ack_tid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_ack_i && (r_outst != '0)) |-> (mem_ack_tid_i == w_tid[r_ret_ptr]));
endmodule
